// File: rtl/cam_ov7670_emulator.sv
// OV7670-style camera source: divided pixel clock, vsync/href framing
// and RGB565 test patterns sent high byte first over an 8-bit bus.
module cam_ov7670_emulator #(
  parameter int TAM_LINE       = 320,
  parameter int TAM_ROW        = 120,
  parameter int BLACK_TAM_LINE = 4,
  parameter int BLACK_TAM_ROW  = 4,
  parameter int PCLK_DIV       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [15:0] solid_color,
  output logic        CAM_pclk,
  output logic        CAM_vsync,
  output logic        CAM_href,
  output logic [7:0]  CAM_px_data,
  output logic        busy,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam logic [9:0] LINE_END = 10'(TAM_LINE + BLACK_TAM_LINE - 1);
  localparam logic [9:0] ROW_END  = 10'(TAM_ROW + BLACK_TAM_ROW - 1);
  localparam logic [9:0] VS_ROWS  = 10'(BLACK_TAM_ROW / 2);
  localparam logic [9:0] BLK_ROWS = 10'(BLACK_TAM_ROW);
  localparam logic [9:0] ACT_LINE = 10'(TAM_LINE);
  localparam logic [7:0] RISE_AT  = 8'(PCLK_DIV / 2 - 1);
  localparam logic [7:0] FALL_AT  = 8'(PCLK_DIV - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state, state_n;
  logic [7:0]  div;
  logic        rise, fall;
  logic [9:0]  line_cnt, line_n;
  logic [9:0]  row_cnt, row_n;
  logic [1:0]  pat, pat_n;
  logic [15:0] color, color_n;
  logic        vsync_n, href_n, done_n;
  logic [7:0]  data_n, cnt_n;
  logic [8:0]  x, bar;
  logic [5:0]  y_hi;
  logic [15:0] px;

  assign rise = (div == RISE_AT);
  assign fall = (div == FALL_AT);
  assign busy = (state == RUN);

  // Free-running divider producing the pixel clock
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div      <= '0;
      CAM_pclk <= 1'b0;
    end else begin
      div <= fall ? 8'd0 : div + 8'd1;
      if (rise)
        CAM_pclk <= 1'b1;
      else if (fall)
        CAM_pclk <= 1'b0;
    end
  end

  // Frame state, counters and registered camera outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      line_cnt    <= '0;
      row_cnt     <= '0;
      pat         <= '0;
      color       <= '0;
      CAM_vsync   <= 1'b0;
      CAM_href    <= 1'b0;
      CAM_px_data <= '0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_n;
      line_cnt    <= line_n;
      row_cnt     <= row_n;
      pat         <= pat_n;
      color       <= color_n;
      CAM_vsync   <= vsync_n;
      CAM_href    <= href_n;
      CAM_px_data <= data_n;
      frame_done  <= done_n;
      frame_cnt   <= cnt_n;
    end
  end

  // Next state, counters and pixel byte, evaluated on each pclk fall
  always_comb begin
    state_n = state;
    line_n  = line_cnt;
    row_n   = row_cnt;
    pat_n   = pat;
    color_n = color;
    vsync_n = CAM_vsync;
    href_n  = CAM_href;
    data_n  = CAM_px_data;
    cnt_n   = frame_cnt;
    done_n  = 1'b0;
    x       = '0;
    bar     = '0;
    y_hi    = '0;
    px      = '0;
    if (fall) begin
      unique case (state)
        IDLE: begin
          if (enable) begin
            state_n = RUN;
            line_n  = '0;
            row_n   = '0;
            pat_n   = pattern_sel;
            color_n = solid_color;
          end
        end
        RUN: begin
          if (line_cnt == LINE_END) begin
            line_n = '0;
            if (row_cnt == ROW_END) begin
              row_n  = '0;
              done_n = 1'b1;
              cnt_n  = frame_cnt + 8'd1;
              if (enable) begin
                pat_n   = pattern_sel;
                color_n = solid_color;
              end else begin
                state_n = IDLE;
              end
            end else begin
              row_n = row_cnt + 10'd1;
            end
          end else begin
            line_n = line_cnt + 10'd1;
          end
        end
      endcase

      x    = line_n[9:1];
      bar  = x / 9'd20;
      y_hi = 6'((row_n - BLK_ROWS) >> 1);

      unique case (pat_n)
        2'd0: px = color_n;
        2'd1: begin
          case (bar)
            9'd0:    px = 16'hFFFF;
            9'd1:    px = 16'hFFE0;
            9'd2:    px = 16'h07FF;
            9'd3:    px = 16'h07E0;
            9'd4:    px = 16'hF81F;
            9'd5:    px = 16'hF800;
            9'd6:    px = 16'h001F;
            default: px = 16'h0000;
          endcase
        end
        2'd2: px = (x[3] ^ y_hi[2]) ? 16'hFFFF : 16'h0000;
        2'd3: px = {x[7:3], y_hi, 5'b0};
      endcase

      vsync_n = (state_n == RUN) && (row_n < VS_ROWS);
      href_n  = (state_n == RUN) && (row_n >= BLK_ROWS)
                && (line_n < ACT_LINE);
      data_n  = !href_n ? 8'h00 :
                line_n[0] ? px[7:0] : px[15:8];
    end
  end

endmodule

// File: tb/tb_cam_ov7670_emulator.sv
// Directed bench for cam_ov7670_emulator: framing, patterns,
// mid-frame disable, asynchronous reset and frame counter wrap.
module tb_cam_ov7670_emulator;

  localparam int LT = 324;
  localparam int RT = 13;
  localparam int FR = LT * RT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, enable;
  logic [1:0]  pattern_sel;
  logic [15:0] solid_color;
  logic        CAM_pclk, CAM_vsync, CAM_href;
  logic [7:0]  CAM_px_data;
  logic        busy, frame_done;
  logic [7:0]  frame_cnt;

  logic        w_rst_n, w_en;
  logic        w_pclk, w_vsync, w_href, w_busy, w_done;
  logic [7:0]  w_data, w_cnt;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  bit dead = 0;
  int bad, vs_hi, hr_hi, hr_rise, first_hr;
  logic [7:0] b0 [LT];
  logic [7:0] b8 [LT];

  cam_ov7670_emulator #(
    .TAM_LINE(320), .TAM_ROW(9), .BLACK_TAM_LINE(4),
    .BLACK_TAM_ROW(4), .PCLK_DIV(4)
  ) u_dut (
    .clk(clk), .rst(rst_n), .enable(enable),
    .pattern_sel(pattern_sel), .solid_color(solid_color),
    .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync),
    .CAM_href(CAM_href), .CAM_px_data(CAM_px_data),
    .busy(busy), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  cam_ov7670_emulator #(
    .TAM_LINE(4), .TAM_ROW(2), .BLACK_TAM_LINE(2),
    .BLACK_TAM_ROW(2), .PCLK_DIV(2)
  ) u_wrap (
    .clk(clk), .rst(w_rst_n), .enable(w_en),
    .pattern_sel(2'd0), .solid_color(16'h1234),
    .CAM_pclk(w_pclk), .CAM_vsync(w_vsync),
    .CAM_href(w_href), .CAM_px_data(w_data),
    .busy(w_busy), .frame_done(w_done), .frame_cnt(w_cnt)
  );

  always @(negedge clk)
    if (frame_done === 1'b1) done_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pclk_tick();
    int n;
    logic last;
    bit got;
    if (dead) return;
    n = 0;
    got = 0;
    while (!got && n < 64) begin
      last = CAM_pclk;
      @(posedge clk);
      #1;
      n++;
      if (CAM_pclk === 1'b1 && last === 1'b0) got = 1;
    end
    if (!got) begin
      chk("pclk_timeout", 32'(n), 32'd0);
      dead = 1;
    end
  endtask

  task automatic wait_vsync();
    int k;
    k = 0;
    while (CAM_vsync !== 1'b1 && k < 32) begin
      pclk_tick();
      k++;
    end
    chk("vsync_start", 32'(CAM_vsync), 32'd1);
  endtask

  function automatic logic [15:0] pix(input logic [1:0] pat,
                                      input logic [15:0] sc,
                                      input int x, input int y);
    logic [7:0] xv;
    logic [6:0] yv;
    xv = x[7:0];
    yv = y[6:0];
    case (pat)
      2'd0: return sc;
      2'd1: begin
        case (x / 20)
          0: return 16'hFFFF;
          1: return 16'hFFE0;
          2: return 16'h07FF;
          3: return 16'h07E0;
          4: return 16'hF81F;
          5: return 16'hF800;
          6: return 16'h001F;
          default: return 16'h0000;
        endcase
      end
      2'd2: return (xv[3] ^ yv[3]) ? 16'hFFFF : 16'h0000;
      default: return {xv[7:3], yv[6:1], 5'b0};
    endcase
  endfunction

  task automatic frame_scan(input int npclk, input logic [1:0] pat,
                            input logic [15:0] sc, input int drop_at);
    int row, ln;
    logic ev, eh, ph;
    logic [7:0] ed;
    logic [15:0] p;
    bad = 0; vs_hi = 0; hr_hi = 0; hr_rise = 0; first_hr = -1;
    ph = 1'b0;
    for (int i = 0; i < npclk; i++) begin
      if (i > 0) pclk_tick();
      if (i == drop_at) begin
        enable = 1'b0;
        pattern_sel = 2'd3;
      end
      row = i / LT;
      ln  = i % LT;
      ev  = (row < 2);
      eh  = (row >= 4) && (ln < 320);
      p   = pix(pat, sc, ln / 2, row - 4);
      ed  = !eh ? 8'h00 : (ln % 2 == 1) ? p[7:0] : p[15:8];
      if (CAM_vsync !== ev || CAM_href !== eh ||
          CAM_px_data !== ed || busy !== 1'b1) bad++;
      if (CAM_vsync === 1'b1) vs_hi++;
      if (CAM_href === 1'b1) hr_hi++;
      if (CAM_href === 1'b1 && !ph) begin
        hr_rise++;
        if (first_hr < 0) first_hr = i;
      end
      ph = (CAM_href === 1'b1);
      if (row == 4) b0[ln] = CAM_px_data;
      if (row == 12) b8[ln] = CAM_px_data;
    end
  endtask

  initial begin
    int n, act, snap, cyc, nd, perr;
    logic wp;
    logic [7:0] c255;

    rst_n = 1'b0; enable = 1'b0;
    pattern_sel = 2'd0; solid_color = 16'hE0A5;
    w_rst_n = 1'b0; w_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pclk", 32'(CAM_pclk), 32'd0);
    chk("rst_vsync", 32'(CAM_vsync), 32'd0);
    chk("rst_href", 32'(CAM_href), 32'd0);
    chk("rst_data", 32'(CAM_px_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_fcnt", 32'(frame_cnt), 32'd0);

    enable = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (CAM_pclk !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("first_rise_clks", 32'(n), 32'd2);

    wait_vsync();
    chk("f1_busy", 32'(busy), 32'd1);
    pattern_sel = 2'd2;
    solid_color = 16'h1234;
    frame_scan(FR, 2'd0, 16'hE0A5, -1);
    chk("f1_model", 32'(bad), 32'd0);
    chk("f1_vsync_pclks", 32'(vs_hi), 32'd648);
    chk("f1_href_pclks", 32'(hr_hi), 32'd2880);
    chk("f1_href_pulses", 32'(hr_rise), 32'd9);
    chk("f1_first_href", 32'(first_hr), 32'd1296);
    chk("f1_byte0", 32'(b0[0]), 32'hE0);
    chk("f1_byte1", 32'(b0[1]), 32'hA5);
    chk("f1_no_early_done", 32'(done_cnt), 32'd0);

    pclk_tick();
    chk("f1_done", 32'(done_cnt), 32'd1);
    chk("f1_fcnt", 32'(frame_cnt), 32'd1);
    chk("f2_seamless_vsync", 32'(CAM_vsync), 32'd1);
    pattern_sel = 2'd1;
    frame_scan(FR, 2'd2, 16'h1234, -1);
    chk("f2_model", 32'(bad), 32'd0);
    chk("chk_y0_x0", 32'({b0[0], b0[1]}), 32'h0000);
    chk("chk_y0_x8", 32'({b0[16], b0[17]}), 32'hFFFF);
    chk("chk_y8_x0", 32'({b8[0], b8[1]}), 32'hFFFF);
    chk("chk_y8_x8", 32'({b8[16], b8[17]}), 32'h0000);

    pclk_tick();
    chk("f2_fcnt", 32'(frame_cnt), 32'd2);
    frame_scan(FR, 2'd1, 16'h1234, 6 * LT);
    chk("f3_model", 32'(bad), 32'd0);
    chk("bar_b0", 32'({b0[0], b0[1]}), 32'hFFFF);
    chk("bar_b40", 32'({b0[40], b0[41]}), 32'hFFE0);
    chk("bar_b120", 32'({b0[120], b0[121]}), 32'h07E0);
    chk("bar_b300", 32'({b0[300], b0[301]}), 32'h0000);
    chk("bar_blank", 32'(b0[321]), 32'h00);

    pclk_tick();
    chk("f3_idle_busy", 32'(busy), 32'd0);
    chk("f3_fcnt", 32'(frame_cnt), 32'd3);
    chk("f3_done", 32'(done_cnt), 32'd3);
    act = 0;
    repeat (50) begin
      pclk_tick();
      if (CAM_vsync !== 1'b0 || CAM_href !== 1'b0 ||
          busy !== 1'b0 || CAM_px_data !== 8'h00) act++;
    end
    chk("idle_quiet", 32'(act), 32'd0);

    enable = 1'b1;
    wait_vsync();
    frame_scan(5 * LT + 101, 2'd3, 16'h0000, -1);
    chk("f4_model", 32'(bad), 32'd0);
    chk("grad_x40", 32'({b0[80], b0[81]}), 32'h2800);
    chk("pre_rst_href", 32'(CAM_href), 32'd1);

    snap = done_cnt;
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pclk", 32'(CAM_pclk), 32'd0);
    chk("ar_vsync", 32'(CAM_vsync), 32'd0);
    chk("ar_href", 32'(CAM_href), 32'd0);
    chk("ar_data", 32'(CAM_px_data), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    chk("ar_fcnt", 32'(frame_cnt), 32'd0);
    repeat (10) @(posedge clk);
    chk("ar_no_done", 32'(done_cnt), 32'(snap));
    @(negedge clk);
    rst_n = 1'b1;
    wait_vsync();
    chk("rs_fcnt", 32'(frame_cnt), 32'd0);
    chk("rs_busy", 32'(busy), 32'd1);

    cyc = 0; nd = 0; perr = 0; wp = 1'b0; c255 = 8'h00;
    @(negedge clk);
    w_rst_n = 1'b1;
    while (nd < 256 && cyc < 14000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (w_pclk === wp) perr++;
      wp = w_pclk;
      if (w_done === 1'b1) begin
        nd++;
        if (nd == 255) c255 = w_cnt;
      end
    end
    chk("wrap_frames", 32'(nd), 32'd256);
    chk("wrap_cycles", 32'(cyc), 32'd12290);
    chk("wrap_cnt255", 32'(c255), 32'd255);
    chk("wrap_cnt0", 32'(w_cnt), 32'd0);
    chk("wrap_pclk_period", 32'(perr), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cam_ov7670_emulator.md
Name: cam_ov7670_emulator

Overview:
- Synthesizable OV7670 timing and pixel-pattern transmitter.
- Drives the same CAM_pclk/CAM_vsync/CAM_href/CAM_px_data interface that the camera capture path receives.
- Used for on-board bring-up and closed-loop simulation of capture → buffer → VGA without a physical camera.
- Output format is RGB565, two bytes per pixel, 160x120 active window.

Parameters:
- TAM_LINE, 320, active bytes per line (160 px x 2 bytes).
- TAM_ROW, 120, active rows per frame.
- BLACK_TAM_LINE, 4, blank pclk cycles per line after active bytes.
- BLACK_TAM_ROW, 4, blank rows at frame start; must be even and ≥2.
- PCLK_DIV, 4, clk cycles per CAM_pclk period; must be even and ≥2.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous active-low reset.
- enable, in, 1, run request; sampled only at frame boundaries.
- pattern_sel, in, 2, 0 = solid, 1 = colour bars, 2 = checker, 3 = gradient.
- solid_color, in, 16, RGB565 value used when pattern_sel = 0.
- CAM_pclk, out, 1, generated pixel clock.
- CAM_vsync, out, 1, frame sync, active high.
- CAM_href, out, 1, line valid, active high.
- CAM_px_data, out, 8, pixel byte.
- busy, out, 1, high while a frame is in progress.
- frame_done, out, 1, one-clk pulse at end of each frame.
- frame_cnt, out, 8, frames completed; wraps 255 → 0.

Behaviour:
- Reset (rst = 0, asynchronous):
  - All outputs 0; state IDLE; divider, line_cnt and row_cnt cleared.
  - Reset mid-frame aborts immediately with no frame_done pulse.
- CAM_pclk:
  - Free-runs from reset release, toggling every PCLK_DIV/2 clk cycles; first rising edge at PCLK_DIV/2 clks after release.
  - All other CAM_* outputs update only on the clk cycle that makes CAM_pclk fall, so they are stable at every rising edge.
- States:
  - IDLE: vsync, href and data are 0. If enable = 1 at a pclk fall, latch pattern_sel/solid_color, clear counters, go to RUN; vsync goes 1 on that same fall.
  - RUN: each pclk fall, line_cnt increments. When line_cnt reaches TAM_LINE+BLACK_TAM_LINE−1, it wraps to 0 and row_cnt increments. When row_cnt wraps from TAM_ROW+BLACK_TAM_ROW−1, the frame ends: frame_done pulses, frame_cnt increments, and the block re-samples enable. If enable = 1, the next frame starts seamlessly (row 0 follows, patterns re-latched); otherwise the block goes to IDLE.
  - Deasserting enable mid-frame never truncates the frame.
- Signal rules (RUN):
  - vsync = 1 while row_cnt < BLACK_TAM_ROW/2, else 0.
  - href = 1 while row_cnt ≥ BLACK_TAM_ROW and line_cnt < TAM_LINE, else 0.
  - px_data = 0 whenever href = 0.
- Pixel coordinates: x = line_cnt[9:1] (0..159), y = row_cnt − BLACK_TAM_ROW (0..119). Even line_cnt sends the high byte of pixel P; odd line_cnt sends the low byte.
- Patterns:
  - 0: P = latched solid_color.
  - 1: 8 bars, 20 px each, bar index = x/20: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 2: P = (x[3] ^ y[3]) ? FFFF : 0000.
  - 3: P = {x[7:3], y[6:1], 5'b0}.
- busy = 1 in RUN.
- Counters are 10 bits; no counter ever exceeds its terminal value.
- Defaults: 324 pclk per line, 124 rows, 40176 pclk per frame.

Test Plan:
- Reset, enable = 1, pattern_sel = 0, solid_color = E0A5 → vsync high for exactly 648 pclk; first href rise at row 4; each line has 320 href-high pclks; bytes alternate E0, A5; 120 href pulses per frame; frame_done once per 40176 pclk; frame_cnt = 1.
- pattern_sel = 1 → bytes 0..1 = FF,FF; bytes 40..41 = FF,E0; bytes 300..301 = 00,00; href low data = 00.
- pattern_sel = 2 → row y=0: x=8 gives FFFF. Row y=8: x=0 gives FFFF, x=8 gives 0000.
- Change pattern_sel and deassert enable at row 60 → current frame completes unchanged and ends with frame_done; block returns to IDLE with busy = 0 and vsync/href held at 0.
- Assert rst low at row 50 → all outputs 0 asynchronously; after release with enable = 1, a fresh frame starts with vsync = 1 and frame_cnt = 0.
- Run 256 frames with PCLK_DIV = 2 → frame_cnt wraps to 0; CAM_pclk period is 2 clk throughout.
